// File: rtl/arrow_lane_scheduler.sv
// arrow_lane_scheduler: launches arrows on four lanes, judges button presses
// against arrow height, and keeps score, lives and game-over state.
module arrow_lane_scheduler #(
   parameter logic [9:0] HIT_LO     = 10'd380,
   parameter logic [9:0] HIT_HI     = 10'd430,
   parameter logic [9:0] MISS_Y     = 10'd455,
   parameter logic [5:0] SPAWN_MIN  = 6'd20,
   parameter logic [1:0] LIVES_INIT = 2'd3,
   parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        animate,
   input  logic [3:0]  btn,
   input  logic [39:0] lane_y,
   output logic [3:0]  lane_hold,
   output logic [3:0]  lane_active,
   output logic [9:0]  score,
   output logic [1:0]  lives,
   output logic [3:0]  hit_pulse,
   output logic [3:0]  miss_pulse,
   output logic        game_over
);
   typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
   state_t      state_q, state_d;
   logic [7:0]  lfsr_q;
   logic [3:0]  btn_q, active_q, active_d, hold_q, hold_d, hit_q, miss_q;
   logic [9:0]  score_q, score_d;
   logic [1:0]  lives_q, lives_d;
   logic        over_q;
   logic [5:0]  cnt_q, cnt_d;
   logic [3:0]  rise, hit, miss, spawn;
   logic [9:0]  y;
   logic [1:0]  idx;
   logic [2:0]  nhit, nmiss;
   logic [10:0] sum;
   logic        live, attempt;

   assign rise    = btn & ~btn_q;
   assign live    = state_q == PLAY && lives_q != 2'd0 && !start;
   assign attempt = live && animate && cnt_q >= SPAWN_MIN + {2'b0, lfsr_q[7:4]};
   assign nhit    = {2'b0, hit[0]} + {2'b0, hit[1]} + {2'b0, hit[2]} + {2'b0, hit[3]};
   assign nmiss   = {2'b0, miss[0]} + {2'b0, miss[1]} + {2'b0, miss[2]} + {2'b0, miss[3]};
   assign sum     = {1'b0, score_q} + {8'b0, nhit};

   always_comb begin
      hit   = '0;
      miss  = '0;
      spawn = '0;
      y     = '0;
      idx   = '0;
      for (int i = 0; i < 4; i++) begin
         y       = lane_y[10*i +: 10];
         hit[i]  = live && active_q[i] && rise[i] && y >= HIT_LO && y <= HIT_HI;
         miss[i] = live && active_q[i] && y >= MISS_Y;
      end
      // Scan uses the pre-judgement mask, so a lane freed this cycle waits a cycle.
      for (int k = 0; k < 4; k++) begin
         idx = lfsr_q[1:0] + 2'(k);
         if (attempt && spawn == 4'h0 && !active_q[idx]) spawn[idx] = 1'b1;
      end
   end

   always_comb begin
      state_d  = start ? PLAY : (state_q == PLAY && lives_q == 2'd0) ? OVER : state_q;
      active_d = live ? (active_q & ~hit & ~miss) | spawn : 4'h0;
      hold_d   = (state_d == PLAY && !start) ? ~active_q : 4'hF;
      score_d  = start ? 10'd0 : live ? (sum > 11'd999 ? 10'd999 : sum[9:0]) : score_q;
      lives_d  = start ? LIVES_INIT :
                 live ? ({1'b0, lives_q} > nmiss ? lives_q - nmiss[1:0] : 2'd0) : lives_q;
      cnt_d    = (start || attempt) ? 6'd0 : (live && animate) ? cnt_q + 6'd1 : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         lfsr_q   <= LFSR_SEED;
         btn_q    <= '0;
         active_q <= '0;
         hold_q   <= 4'hF;
         hit_q    <= '0;
         miss_q   <= '0;
         score_q  <= '0;
         lives_q  <= '0;
         over_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
         btn_q    <= btn;
         active_q <= active_d;
         hold_q   <= hold_d;
         hit_q    <= hit;
         miss_q   <= miss;
         score_q  <= score_d;
         lives_q  <= lives_d;
         over_q   <= state_d == OVER;
         cnt_q    <= cnt_d;
      end
   end

   assign lane_hold   = hold_q;
   assign lane_active = active_q;
   assign score       = score_q;
   assign lives       = lives_q;
   assign hit_pulse   = hit_q;
   assign miss_pulse  = miss_q;
   assign game_over   = over_q;
endmodule

// File: tb/tb_arrow_lane_scheduler.sv
// tb_arrow_lane_scheduler: directed vectors and corner sequences for the lane scheduler.
module tb_arrow_lane_scheduler;
   logic        clk = 1'b0, rst = 1'b0, start = 1'b0, animate = 1'b0;
   logic [3:0]  btn = 4'hF;
   logic [39:0] lane_y = '0;
   logic [3:0]  lane_hold, lane_active, hit_pulse, miss_pulse;
   logic [9:0]  score;
   logic [1:0]  lives;
   logic        game_over;

   int total = 0, bad = 0;
   logic [7:0] m_lfsr;
   int         m_cnt;
   logic       m_play = 1'b0;

   typedef struct {
      logic [3:0]  btn;
      logic [39:0] y;
      logic [3:0]  act, hit, miss, hold;
      logic [9:0]  sc;
      logic [1:0]  lv;
   } vec_t;
   vec_t tbl[10];

   arrow_lane_scheduler dut (
      .clk(clk), .rst(rst), .start(start), .animate(animate), .btn(btn), .lane_y(lane_y),
      .lane_hold(lane_hold), .lane_active(lane_active), .score(score), .lives(lives),
      .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .game_over(game_over)
   );

   always #5 clk = ~clk;

   // Reference for the random source and spawn counter, used to predict spawn timing.
   always @(posedge clk) begin
      if (!rst) begin
         m_lfsr <= 8'hA5;
         m_cnt  <= 0;
      end else begin
         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
         if (start) m_cnt <= 0;
         else if (m_play && animate) m_cnt <= (m_cnt >= 20 + int'(m_lfsr[7:4])) ? 0 : m_cnt + 1;
      end
   end

   function automatic logic [39:0] ys(input logic [9:0] y3, y2, y1, y0);
      return {y3, y2, y1, y0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic       found, ok, att, seen;
      logic [1:0] el;
      logic [3:0] e4;
      int         n;
      tbl[0] = '{4'b0100, ys(0, 379, 0, 0),     4'hF,    4'h0,    4'h0,    4'h0,    10'd0, 2'd3};
      tbl[1] = '{4'b0000, ys(0, 379, 0, 0),     4'hF,    4'h0,    4'h0,    4'h0,    10'd0, 2'd3};
      tbl[2] = '{4'b0100, ys(0, 380, 0, 0),     4'b1011, 4'b0100, 4'h0,    4'h0,    10'd1, 2'd3};
      tbl[3] = '{4'b0010, ys(0, 380, 100, 0),   4'b1011, 4'h0,    4'h0,    4'b0100, 10'd1, 2'd3};
      tbl[4] = '{4'b0010, ys(0, 380, 400, 0),   4'b1011, 4'h0,    4'h0,    4'b0100, 10'd1, 2'd3};
      tbl[5] = '{4'b0000, ys(0, 380, 431, 0),   4'b1011, 4'h0,    4'h0,    4'b0100, 10'd1, 2'd3};
      tbl[6] = '{4'b0010, ys(0, 380, 431, 0),   4'b1011, 4'h0,    4'h0,    4'b0100, 10'd1, 2'd3};
      tbl[7] = '{4'b0000, ys(0, 380, 430, 0),   4'b1011, 4'h0,    4'h0,    4'b0100, 10'd1, 2'd3};
      tbl[8] = '{4'b0010, ys(455, 380, 430, 455), 4'h0,  4'b0010, 4'b1001, 4'b0100, 10'd2, 2'd1};
      tbl[9] = '{4'b0000, ys(455, 380, 430, 455), 4'h0,  4'h0,    4'h0,    4'hF,    10'd2, 2'd1};

      tick();
      tick();
      chk("rst_hold", lane_hold, 4'hF);
      chk("rst_active", lane_active, 0);
      chk("rst_score", score, 0);
      chk("rst_lives", lives, 0);
      chk("rst_over", game_over, 0);
      chk("rst_hit", hit_pulse, 0);
      chk("rst_miss", miss_pulse, 0);
      rst = 1'b1;
      btn = 4'h0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      m_play = 1'b1;
      chk("start_lives", lives, 3);
      chk("start_score", score, 0);
      chk("start_active", lane_active, 0);
      chk("start_hold", lane_hold, 4'hF);
      chk("start_over", game_over, 0);

      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         animate = (k % 4 == 0);
         att = animate && m_cnt >= 20 + int'(m_lfsr[7:4]);
         el = m_lfsr[1:0];
         tick();
         if (att) begin
            found = 1'b1;
            e4 = 4'b1 << el;
            chk("spawn_lane", lane_active, e4);
            chk("spawn_hold_pre", lane_hold, 4'hF);
            animate = 1'b0;
            tick();
            e4 = ~(4'b1 << el);
            chk("spawn_hold_drop", lane_hold, e4);
         end else if (lane_active != 4'h0) chk("spawn_early", lane_active, 0);
      end
      animate = 1'b0;
      chk("spawn_found", found, 1);

      animate = 1'b1;
      for (int k = 0; k < 400 && lane_active != 4'hF; k++) tick();
      animate = 1'b0;
      tick();
      chk("fill_active", lane_active, 4'hF);
      chk("fill_hold", lane_hold, 0);

      ok = 1'b1;
      animate = 1'b1;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (lane_active != 4'hF || hit_pulse != 4'h0 || miss_pulse != 4'h0) ok = 1'b0;
      end
      animate = 1'b0;
      chk("full_no_spawn", ok, 1);

      for (int i = 0; i < 10; i++) begin
         btn = tbl[i].btn;
         lane_y = tbl[i].y;
         tick();
         chk($sformatf("r%0d_active", i), lane_active, tbl[i].act);
         chk($sformatf("r%0d_hit", i), hit_pulse, tbl[i].hit);
         chk($sformatf("r%0d_miss", i), miss_pulse, tbl[i].miss);
         chk($sformatf("r%0d_hold", i), lane_hold, tbl[i].hold);
         chk($sformatf("r%0d_score", i), score, tbl[i].sc);
         chk($sformatf("r%0d_lives", i), lives, tbl[i].lv);
      end
      btn = 4'h0;
      lane_y = '0;

      found = 1'b0;
      el = 2'd0;
      animate = 1'b1;
      for (int k = 0; k < 100 && !found; k++) begin
         att = m_cnt >= 20 + int'(m_lfsr[7:4]);
         el = m_lfsr[1:0];
         tick();
         if (att) begin
            found = 1'b1;
            e4 = 4'b1 << el;
            chk("respawn_lane", lane_active, e4);
         end
      end
      animate = 1'b0;
      chk("respawn_found", found, 1);

      lane_y = 40'(460) << (10 * el);
      tick();
      e4 = 4'b1 << el;
      chk("last_miss", miss_pulse, e4);
      chk("last_lives", lives, 0);
      chk("last_over_lag", game_over, 0);
      chk("last_active", lane_active, 0);
      tick();
      m_play = 1'b0;
      chk("over_flag", game_over, 1);
      chk("over_hold", lane_hold, 4'hF);
      chk("over_active", lane_active, 0);
      chk("over_miss", miss_pulse, 0);
      lane_y = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      m_play = 1'b1;
      chk("restart_lives", lives, 3);
      chk("restart_score", score, 0);
      chk("restart_over", game_over, 0);

      lane_y = ys(400, 400, 400, 400);
      animate = 1'b1;
      n = 0;
      while (score != 10'd999 && n < 60000) begin
         btn = (n % 2 == 1) ? 4'hF : 4'h0;
         tick();
         n++;
      end
      chk("sat_reach", score, 999);
      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         btn = (k % 2 == 1) ? 4'hF : 4'h0;
         tick();
         if (hit_pulse != 4'h0) begin
            seen = 1'b1;
            chk("sat_hold", score, 999);
         end
      end
      chk("sat_hit_seen", seen, 1);
      chk("grind_lives", lives, 3);

      rst = 1'b0;
      animate = 1'b0;
      btn = 4'h0;
      tick();
      chk("midrst_hold", lane_hold, 4'hF);
      chk("midrst_active", lane_active, 0);
      chk("midrst_score", score, 0);
      chk("midrst_lives", lives, 0);
      chk("midrst_hit", hit_pulse, 0);
      rst = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
